// File: rtl/shadow_regfile_pkg.sv
// Shared types and helpers for the interrupt shadow register file.
package shadow_reg_pkg;

  localparam int unsigned MAX_SHADOW_SAVES = 16;
  localparam int unsigned ARCH_ADDR_WIDTH  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } xfer_state_e;

  // Map a shadow entry index onto the caller-saved architectural register.
  function automatic logic [ARCH_ADDR_WIDTH-1:0] shadow_idx_to_arch(input logic [3:0] idx);
    logic [ARCH_ADDR_WIDTH-1:0] arch;
    if (idx == 4'd0) begin
      arch = 5'd1;
    end else if (idx <= 4'd3) begin
      arch = 5'(idx) + 5'd4;
    end else if (idx <= 4'd11) begin
      arch = 5'(idx) + 5'd6;
    end else begin
      arch = 5'(idx) + 5'd16;
    end
    return arch;
  endfunction

endpackage

// File: rtl/shadow_regfile_if.sv
// Bus bundle between the shadow register controller/arch regfile and the shadow storage.
interface shadow_regfile_if #(
  parameter int unsigned ADDR_WIDTH       = 6,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned NUM_SHADOW_SAVES = 16
);

  logic                                   capture_i;
  logic [NUM_SHADOW_SAVES*DATA_WIDTH-1:0] arch_rdata_i;
  logic [ADDR_WIDTH-1:0]                  raddr_i;
  logic [DATA_WIDTH-1:0]                  rdata_o;
  logic [ADDR_WIDTH-1:0]                  waddr_i;
  logic [DATA_WIDTH-1:0]                  wdata_i;
  logic                                   we_i;
  logic                                   load_i;
  logic [4:0]                             arch_waddr_o;
  logic [DATA_WIDTH-1:0]                  arch_wdata_o;
  logic                                   arch_we_o;
  logic                                   arch_wready_i;
  logic                                   busy_o;
  logic                                   done_o;
  logic                                   err_o;

  modport master (
    output capture_i, arch_rdata_i, raddr_i, waddr_i, wdata_i, we_i, load_i, arch_wready_i,
    input  rdata_o, arch_waddr_o, arch_wdata_o, arch_we_o, busy_o, done_o, err_o
  );

  modport slave (
    input  capture_i, arch_rdata_i, raddr_i, waddr_i, wdata_i, we_i, load_i, arch_wready_i,
    output rdata_o, arch_waddr_o, arch_wdata_o, arch_we_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/shadow_regfile.sv
// Interrupt shadow context storage: snapshot, controller read/write port, arch write-back.
module shadow_regfile
  import shadow_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 6,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned NUM_SHADOW_SAVES = 16
) (
  input logic             clk_i,
  input logic             rst_ni,
  shadow_regfile_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_SHADOW_SAVES > 1) ? $clog2(NUM_SHADOW_SAVES) : 1;
  localparam int unsigned LAST  = NUM_SHADOW_SAVES - 1;

  generate
    if (NUM_SHADOW_SAVES < 1 || NUM_SHADOW_SAVES > MAX_SHADOW_SAVES) begin : g_bad_num
      $error("shadow_regfile: NUM_SHADOW_SAVES must be within 1..16");
    end
  endgenerate

  xfer_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] entries [NUM_SHADOW_SAVES];
  logic                  waddr_ok;
  logic                  raddr_ok;
  logic                  xfer;

  assign waddr_ok = bus.waddr_i < ADDR_WIDTH'(NUM_SHADOW_SAVES);
  assign raddr_ok = bus.raddr_i < ADDR_WIDTH'(NUM_SHADOW_SAVES);
  assign xfer     = (state_q == XFER);

  // Combinational read port; out-of-range indices read as zero.
  assign bus.rdata_o = raddr_ok ? entries[IDX_W'(bus.raddr_i)] : '0;

  // Write-back drive; everything quiet outside XFER.
  assign bus.arch_we_o    = xfer;
  assign bus.busy_o       = xfer;
  assign bus.arch_waddr_o = xfer ? shadow_idx_to_arch(4'(idx_q)) : '0;
  assign bus.arch_wdata_o = xfer ? entries[IDX_W'(idx_q)] : '0;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;

  // State, index and status flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= ADDR_WIDTH'(LAST);
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, index stepping and protocol-violation detection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = bus.we_i && !waddr_ok;
        if (bus.load_i) begin
          state_d = XFER;
          idx_d   = ADDR_WIDTH'(LAST);
        end
      end
      XFER: begin
        err_d = bus.capture_i || bus.we_i || bus.load_i;
        if (bus.arch_wready_i) begin
          if (idx_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            idx_d   = ADDR_WIDTH'(LAST);
          end else begin
            idx_d = idx_q - ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry storage: frozen during XFER; a write beats a same-cycle capture on its index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_SHADOW_SAVES); i++) begin
        entries[i] <= '0;
      end
    end else if (state_q == IDLE) begin
      for (int i = 0; i < int'(NUM_SHADOW_SAVES); i++) begin
        if (bus.we_i && waddr_ok && (bus.waddr_i == ADDR_WIDTH'(i))) begin
          entries[i] <= bus.wdata_i;
        end else if (bus.capture_i) begin
          entries[i] <= bus.arch_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_shadow_regfile.sv
// Directed bench for shadow_regfile: capture, controller port, write-back, violations, reset.
module tb_shadow_regfile;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  shadow_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SHADOW_SAVES(N)) bus ();

  shadow_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SHADOW_SAVES(N)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] model [N];
  logic [4:0]  arch_map [N] = '{5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13,
                                5'd14, 5'd15, 5'd16, 5'd17, 5'd28, 5'd29, 5'd30, 5'd31};

  // Single comparison point: count and report.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_arch(input logic [31:0] base);
    for (int i = 0; i < int'(N); i++) bus.arch_rdata_i[i*DW +: DW] = base + 32'(i);
  endtask

  task automatic rd(input string tag, input int a, input logic [31:0] exp);
    bus.raddr_i = AW'(a);
    #1;
    chk(tag, bus.rdata_o, exp);
  endtask

  // Full write-back; optional 3-cycle stall at loop step stall_k and a violation at viol_k.
  task automatic run_xfer(input int stall_k, input int viol_k);
    int idx;
    bus.load_i = 1'b1;
    step();
    bus.load_i = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      idx = int'(N) - 1 - k;
      chk("wb_we",   32'(bus.arch_we_o),    32'd1);
      chk("wb_busy", 32'(bus.busy_o),       32'd1);
      chk("wb_addr", 32'(bus.arch_waddr_o), 32'(arch_map[idx]));
      chk("wb_data", bus.arch_wdata_o,      model[idx]);
      if (k == viol_k) begin
        bus.we_i      = 1'b1;
        bus.waddr_i   = AW'(0);
        bus.wdata_i   = 32'hBEEF_0000;
        bus.capture_i = 1'b1;
        set_arch(32'h5555_0000);
      end
      if (k == stall_k) begin
        bus.arch_wready_i = 1'b0;
        repeat (3) begin
          step();
          chk("stall_we",   32'(bus.arch_we_o),    32'd1);
          chk("stall_addr", 32'(bus.arch_waddr_o), 32'(arch_map[idx]));
          chk("stall_data", bus.arch_wdata_o,      model[idx]);
        end
        bus.arch_wready_i = 1'b1;
      end
      step();
      if (k == viol_k) begin
        bus.we_i      = 1'b0;
        bus.capture_i = 1'b0;
        chk("viol_err", 32'(bus.err_o), 32'd1);
      end
    end
    chk("done_pulse", 32'(bus.done_o),       32'd1);
    chk("done_busy",  32'(bus.busy_o),       32'd0);
    chk("done_we",    32'(bus.arch_we_o),    32'd0);
    chk("done_addr",  32'(bus.arch_waddr_o), 32'd0);
    chk("done_data",  bus.arch_wdata_o,      32'd0);
    chk("done_err",   32'(bus.err_o),        32'd0);
    step();
    chk("done_clear", 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    bus.capture_i     = 1'b0;
    bus.arch_rdata_i  = '0;
    bus.raddr_i       = '0;
    bus.waddr_i       = '0;
    bus.wdata_i       = '0;
    bus.we_i          = 1'b0;
    bus.load_i        = 1'b0;
    bus.arch_wready_i = 1'b1;
    for (int i = 0; i < int'(N); i++) model[i] = 32'd0;

    // Reset values
    step();
    step();
    chk("rst_we",   32'(bus.arch_we_o),    32'd0);
    chk("rst_busy", 32'(bus.busy_o),       32'd0);
    chk("rst_done", 32'(bus.done_o),       32'd0);
    chk("rst_err",  32'(bus.err_o),        32'd0);
    chk("rst_addr", 32'(bus.arch_waddr_o), 32'd0);
    chk("rst_data", bus.arch_wdata_o,      32'd0);
    rd("rst_rd0", 0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Capture
    set_arch(32'h1000);
    bus.capture_i = 1'b1;
    step();
    bus.capture_i = 1'b0;
    for (int i = 0; i < int'(N); i++) model[i] = 32'h1000 + 32'(i);
    rd("cap_rd5",  5,  32'h1005);
    rd("cap_rd15", 15, 32'h100F);
    rd("cap_rd16", 16, 32'd0);
    rd("cap_rd20", 20, 32'd0);

    // Capture and write in the same cycle
    bus.capture_i = 1'b1;
    bus.we_i      = 1'b1;
    bus.waddr_i   = AW'(3);
    bus.wdata_i   = 32'hDEAD;
    step();
    bus.capture_i = 1'b0;
    bus.we_i      = 1'b0;
    model[3] = 32'hDEAD;
    rd("cw_rd3", 3, 32'hDEAD);
    rd("cw_rd4", 4, 32'h1004);

    // Out-of-range write: ignored (no aliasing onto entry 4), err pulses
    bus.we_i    = 1'b1;
    bus.waddr_i = AW'(20);
    bus.wdata_i = 32'hFFFF_FFFF;
    step();
    bus.we_i = 1'b0;
    chk("oor_err", 32'(bus.err_o), 32'd1);
    rd("oor_rd4", 4, 32'h1004);
    step();
    chk("oor_err_clr", 32'(bus.err_o), 32'd0);

    // Write-back variants
    run_xfer(-1, -1);
    run_xfer(7, -1);
    run_xfer(-1, 4);
    for (int i = 0; i < int'(N); i++) rd("post_rd", i, model[i]);

    // Reset while writing back entry 10 (x16)
    bus.load_i = 1'b1;
    step();
    bus.load_i = 1'b0;
    repeat (5) step();
    chk("mid_addr", 32'(bus.arch_waddr_o), 32'd16);
    rst_n = 1'b0;
    #1;
    chk("mr_we",   32'(bus.arch_we_o),    32'd0);
    chk("mr_busy", 32'(bus.busy_o),       32'd0);
    chk("mr_addr", 32'(bus.arch_waddr_o), 32'd0);
    rd("mr_rd0",  0,  32'd0);
    rd("mr_rd3",  3,  32'd0);
    rd("mr_rd15", 15, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mr_idle", 32'(bus.busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
